// File: rtl/aesl_deadlock_trace_recorder_pkg.sv
// Shared types for the deadlock trace recorder: record kinds, FSM states
// and the trace record layout at the default widths.
package aesl_deadlock_pkg;

    localparam int DEF_PROC_NUM = 4;
    localparam int DEF_TS_W     = 32;

    localparam logic [1:0] KIND_TRANSIENT = 2'b01;
    localparam logic [1:0] KIND_CONFIRMED = 2'b10;
    localparam logic [1:0] KIND_CLEARED   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CONFIRM,
        DONE
    } dl_state_t;

    typedef struct packed {
        logic [1:0]              kind;
        logic [DEF_TS_W-1:0]     ts;
        logic [DEF_PROC_NUM-1:0] origin;
        logic [DEF_PROC_NUM-1:0] blk;
    } trace_rec_t;

endpackage

// File: rtl/aesl_deadlock_trace_recorder_if.sv
// Bundle between the deadlock report stage / trace reader and the recorder.
interface aesl_deadlock_trace_recorder_if #(
    parameter int PROC_NUM = 4,
    parameter int TS_W     = 32
);
    logic                dl_detect_in;
    logic [PROC_NUM-1:0] origin;
    logic                token_clear;
    logic [PROC_NUM-1:0] proc_blk_vec;
    logic                all_finish;
    logic                rd_en;
    logic                rec_valid;
    logic [1:0]          rec_kind;
    logic [TS_W-1:0]     rec_ts;
    logic [PROC_NUM-1:0] rec_origin;
    logic [PROC_NUM-1:0] rec_blk;
    logic                dl_confirmed;
    logic                overflow;
    logic [7:0]          drop_cnt;

    modport master (
        output dl_detect_in, origin, token_clear, proc_blk_vec, all_finish, rd_en,
        input  rec_valid, rec_kind, rec_ts, rec_origin, rec_blk,
               dl_confirmed, overflow, drop_cnt
    );

    modport slave (
        input  dl_detect_in, origin, token_clear, proc_blk_vec, all_finish, rd_en,
        output rec_valid, rec_kind, rec_ts, rec_origin, rec_blk,
               dl_confirmed, overflow, drop_cnt
    );
endinterface

// File: rtl/aesl_trace_fifo.sv
// Show-ahead synchronous FIFO; a write on a full FIFO is accepted only when
// a pop happens on the same edge. Head data reads as zero while empty.
module aesl_trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop     = rd_en && !empty;
    assign push    = wr_en && (!full || pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/aesl_deadlock_trace_recorder.sv
// Qualifies deadlock indications as transient or confirmed, timestamps each
// qualified event and queues the trace records for the testbench to drain.
module aesl_deadlock_trace_recorder
    import aesl_deadlock_pkg::*;
#(
    parameter int PROC_NUM   = DEF_PROC_NUM,
    parameter int DEPTH      = 8,
    parameter int TS_W       = DEF_TS_W,
    parameter int STABLE_CYC = 16
) (
    input logic clock,
    input logic reset,
    aesl_deadlock_trace_recorder_if.slave bus
);
    typedef struct packed {
        logic [1:0]          kind;
        logic [TS_W-1:0]     ts;
        logic [PROC_NUM-1:0] origin;
        logic [PROC_NUM-1:0] blk;
    } rec_t;

    localparam int CW = $clog2(STABLE_CYC);
    localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYC - 1);

    dl_state_t     state;
    logic [CW-1:0] stab_cnt;
    logic [TS_W-1:0] ts_now;
    rec_t          pending;
    rec_t          wr_rec;
    rec_t          head;
    logic          wr_en;
    logic          full;
    logic          empty;
    logic          pop;
    logic          dropped;
    logic          confirmed;
    logic          overflow;
    logic [7:0]    drop_cnt;

    assign pop     = bus.rd_en && !empty;
    assign dropped = wr_en && full && !pop;

    // The record leaving ARM keeps the rise-time snapshot; CLEARED snapshots now.
    always_comb begin
        wr_en  = 1'b0;
        wr_rec = pending;
        if (!bus.all_finish) begin
            case (state)
                ARM: begin
                    if (!bus.dl_detect_in) begin
                        wr_en       = 1'b1;
                        wr_rec.kind = KIND_TRANSIENT;
                    end else if (stab_cnt == STAB_LAST) begin
                        wr_en       = 1'b1;
                        wr_rec.kind = KIND_CONFIRMED;
                    end
                end
                CONFIRM: begin
                    if (!bus.dl_detect_in || bus.token_clear) begin
                        wr_en  = 1'b1;
                        wr_rec = '{kind: KIND_CLEARED, ts: ts_now,
                                   origin: bus.origin, blk: bus.proc_blk_vec};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            stab_cnt  <= '0;
            pending   <= '0;
            confirmed <= 1'b0;
        end else if (bus.all_finish) begin
            state     <= DONE;
            confirmed <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.dl_detect_in) begin
                        state    <= ARM;
                        stab_cnt <= CW'(1);
                        pending  <= '{kind: 2'b00, ts: ts_now,
                                      origin: bus.origin, blk: bus.proc_blk_vec};
                    end
                end
                ARM: begin
                    if (!bus.dl_detect_in) begin
                        state <= IDLE;
                    end else if (stab_cnt == STAB_LAST) begin
                        state     <= CONFIRM;
                        confirmed <= 1'b1;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                CONFIRM: begin
                    if (!bus.dl_detect_in || bus.token_clear) begin
                        state     <= IDLE;
                        confirmed <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Free-running timestamp that sticks at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_now <= '0;
        end else if (ts_now != '1) begin
            ts_now <= ts_now + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (dropped) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    aesl_trace_fifo #(
        .W     ($bits(rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_rec),
        .rd_en   (bus.rd_en),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign bus.rec_valid    = !empty;
    assign bus.rec_kind     = head.kind;
    assign bus.rec_ts       = head.ts;
    assign bus.rec_origin   = head.origin;
    assign bus.rec_blk      = head.blk;
    assign bus.dl_confirmed = confirmed;
    assign bus.overflow     = overflow;
    assign bus.drop_cnt     = drop_cnt;
endmodule

// File: tb/tb_aesl_deadlock_trace_recorder.sv
// Randomized and directed bench; a queue-based reference model predicts the
// trace records and a negedge monitor compares them with the DUT head.
module tb_aesl_deadlock_trace_recorder;
    import aesl_deadlock_pkg::*;

    localparam int DEPTH      = 8;
    localparam int STABLE_CYC = 16;
    localparam int QUIET      = 0;
    localparam int ARMING     = 1;
    localparam int HELD       = 2;
    localparam int FINISHED   = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;

    aesl_deadlock_trace_recorder_if #(.PROC_NUM(DEF_PROC_NUM), .TS_W(DEF_TS_W)) bus();

    aesl_deadlock_trace_recorder #(
        .PROC_NUM   (DEF_PROC_NUM),
        .DEPTH      (DEPTH),
        .TS_W       (DEF_TS_W),
        .STABLE_CYC (STABLE_CYC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    trace_rec_t          model_q[$];
    int                  mode;
    logic [DEF_TS_W-1:0] ts_m;
    logic [DEF_TS_W-1:0] rise_ts;
    trace_rec_t          pend_m;
    trace_rec_t          new_rec;
    bit                  has_rec;
    bit                  pop_m;
    bit                  conf_m;
    bit                  ovf_m;
    int                  drops_m;
    bit                  rnd_d;
    int                  rnd_len;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: events are judged by how long the indication has been high.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            model_q.delete();
            mode    = QUIET;
            ts_m    = '0;
            rise_ts = '0;
            pend_m  = '0;
            conf_m  = 1'b0;
            ovf_m   = 1'b0;
            drops_m = 0;
        end else begin
            has_rec = 1'b0;
            new_rec = '0;
            pop_m   = bus.rd_en && (model_q.size() > 0);
            if (bus.all_finish) begin
                mode   = FINISHED;
                conf_m = 1'b0;
            end else if (mode == QUIET) begin
                if (bus.dl_detect_in) begin
                    mode    = ARMING;
                    rise_ts = ts_m;
                    pend_m  = '{kind: KIND_TRANSIENT, ts: ts_m,
                                origin: bus.origin, blk: bus.proc_blk_vec};
                end
            end else if (mode == ARMING) begin
                if (!bus.dl_detect_in) begin
                    has_rec = 1'b1;
                    new_rec = pend_m;
                    mode    = QUIET;
                end else if (ts_m - rise_ts == STABLE_CYC - 1) begin
                    has_rec      = 1'b1;
                    new_rec      = pend_m;
                    new_rec.kind = KIND_CONFIRMED;
                    mode         = HELD;
                    conf_m       = 1'b1;
                end
            end else if (mode == HELD) begin
                if (!bus.dl_detect_in || bus.token_clear) begin
                    has_rec = 1'b1;
                    new_rec = '{kind: KIND_CLEARED, ts: ts_m,
                                origin: bus.origin, blk: bus.proc_blk_vec};
                    mode    = QUIET;
                    conf_m  = 1'b0;
                end
            end
            if (pop_m) void'(model_q.pop_front());
            if (has_rec) begin
                if (model_q.size() < DEPTH) begin
                    model_q.push_back(new_rec);
                end else begin
                    ovf_m = 1'b1;
                    if (drops_m < 255) drops_m++;
                end
            end
            if (ts_m != '1) ts_m++;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            checkOutput("mon_valid", bus.rec_valid, model_q.size() > 0);
            if (model_q.size() > 0) begin
                checkOutput("mon_kind", bus.rec_kind, model_q[0].kind);
                checkOutput("mon_ts", bus.rec_ts, model_q[0].ts);
                checkOutput("mon_origin", bus.rec_origin, model_q[0].origin);
                checkOutput("mon_blk", bus.rec_blk, model_q[0].blk);
            end
            checkOutput("mon_confirmed", bus.dl_confirmed, conf_m);
            checkOutput("mon_overflow", bus.overflow, ovf_m);
            checkOutput("mon_drop_cnt", bus.drop_cnt, drops_m);
        end
    end

    task automatic applyStimulus(input bit d, input logic [3:0] org, input bit tc,
                                 input logic [3:0] blk, input bit fin, input bit rd);
        bus.dl_detect_in = d;
        bus.origin       = org;
        bus.token_clear  = tc;
        bus.proc_blk_vec = blk;
        bus.all_finish   = fin;
        bus.rd_en        = rd;
        @(negedge clock);
    endtask

    task automatic idleUntil(input logic [31:0] t);
        while (ts_m < t) applyStimulus(0, 4'h0, 0, 4'h0, 0, 0);
    endtask

    task automatic popOne();
        applyStimulus(0, 4'h0, 0, 4'h0, 0, 1);
    endtask

    task automatic checkHead(input string name, input logic [1:0] k, input logic [31:0] t);
        checkOutput({name, "_valid"}, bus.rec_valid, 1);
        checkOutput({name, "_kind"}, bus.rec_kind, k);
        checkOutput({name, "_ts"}, bus.rec_ts, t);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_valid"}, bus.rec_valid, 0);
        checkOutput({name, "_kind"}, bus.rec_kind, 0);
        checkOutput({name, "_ts"}, bus.rec_ts, 0);
        checkOutput({name, "_origin"}, bus.rec_origin, 0);
        checkOutput({name, "_blk"}, bus.rec_blk, 0);
        checkOutput({name, "_confirmed"}, bus.dl_confirmed, 0);
        checkOutput({name, "_overflow"}, bus.overflow, 0);
        checkOutput({name, "_drop_cnt"}, bus.drop_cnt, 0);
    endtask

    // Asserts reset between clock edges and checks the outputs clear at once.
    task automatic asyncResetCheck(input string name);
        #2;
        bus.dl_detect_in = 0; bus.origin = 0; bus.token_clear = 0;
        bus.proc_blk_vec = 0; bus.all_finish = 0; bus.rd_en = 0;
        reset = 1'b0;
        #1;
        checkAllZero(name);
        #1 reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.dl_detect_in = 0; bus.origin = 0; bus.token_clear = 0;
        bus.proc_blk_vec = 0; bus.all_finish = 0; bus.rd_en = 0;
        #1 reset = 1'b0;
        #2 checkAllZero("reset");
        @(negedge clock);
        reset = 1'b1;

        // Short glitch
        idleUntil(100);
        repeat (5) applyStimulus(1, 4'b0010, 0, 4'b0110, 0, 0);
        applyStimulus(0, 4'h0, 0, 4'h0, 0, 0);
        checkHead("glitch", KIND_TRANSIENT, 100);
        checkOutput("glitch_origin", bus.rec_origin, 4'b0010);
        checkOutput("glitch_blk", bus.rec_blk, 4'b0110);
        popOne();
        checkOutput("glitch_popped", bus.rec_valid, 0);

        // Persistent indication, then drop
        idleUntil(200);
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1, 4'b1000, 0, 4'b0101, 0, 0);
            if (i == 14) checkOutput("confirm_pre", bus.dl_confirmed, 0);
            if (i == 15) checkOutput("confirm_rise", bus.dl_confirmed, 1);
        end
        applyStimulus(0, 4'b1000, 0, 4'b0001, 0, 0);
        checkOutput("confirm_fall", bus.dl_confirmed, 0);
        checkHead("confirm_rec", KIND_CONFIRMED, 200);
        checkOutput("confirm_origin", bus.rec_origin, 4'b1000);
        checkOutput("confirm_blk", bus.rec_blk, 4'b0101);
        popOne();
        checkHead("clear_rec", KIND_CLEARED, 230);
        checkOutput("clear_blk", bus.rec_blk, 4'b0001);
        popOne();

        // Token clear while confirmed with the indication still high
        idleUntil(280);
        while (ts_m < 300) applyStimulus(1, 4'b0100, 0, 4'b0011, 0, 0);
        applyStimulus(1, 4'b0100, 1, 4'b1100, 0, 0);
        checkOutput("tc_confirmed", bus.dl_confirmed, 0);
        repeat (4) applyStimulus(1, 4'b0001, 0, 4'b0010, 0, 0);
        applyStimulus(0, 4'h0, 0, 4'h0, 0, 0);
        checkHead("tc_first", KIND_CONFIRMED, 280);
        popOne();
        checkHead("tc_clear", KIND_CLEARED, 300);
        checkOutput("tc_clear_blk", bus.rec_blk, 4'b1100);
        popOne();
        checkHead("tc_rearm", KIND_TRANSIENT, 301);
        checkOutput("tc_rearm_origin", bus.rec_origin, 4'b0001);
        popOne();

        // Ten transients without reads, then a write with a pop on a full FIFO
        idleUntil(320);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 4'(i), 0, 4'(15 - i), 0, 0);
            applyStimulus(0, 4'h0, 0, 4'h0, 0, 0);
        end
        checkOutput("ovf_flag", bus.overflow, 1);
        checkOutput("ovf_drops", bus.drop_cnt, 2);
        checkHead("ovf_oldest", KIND_TRANSIENT, 320);
        applyStimulus(1, 4'hA, 0, 4'h5, 0, 0);
        applyStimulus(0, 4'h0, 0, 4'h0, 0, 1);
        checkOutput("full_rw_drops", bus.drop_cnt, 2);
        checkHead("full_rw_head", KIND_TRANSIENT, 322);
        repeat (7) popOne();
        checkHead("full_rw_last", KIND_TRANSIENT, 340);
        popOne();
        checkOutput("ovf_drained", bus.rec_valid, 0);

        // Randomized segments of high/low indication with random reads
        for (int seg = 0; seg < 60; seg++) begin
            rnd_d   = seg[0];
            rnd_len = $urandom_range(1, 24);
            for (int j = 0; j < rnd_len; j++)
                applyStimulus(rnd_d, 4'($urandom), ($urandom_range(0, 19) == 0),
                              4'($urandom), 0, ($urandom_range(0, 2) == 0));
        end
        repeat (12) popOne();

        // Async reset in CONFIRM with three records queued
        repeat (2) begin
            applyStimulus(1, 4'b0010, 0, 4'b0001, 0, 0);
            applyStimulus(0, 4'h0, 0, 4'h0, 0, 0);
        end
        repeat (17) applyStimulus(1, 4'b1000, 0, 4'b1000, 0, 0);
        checkOutput("pre_reset_confirmed", bus.dl_confirmed, 1);
        checkOutput("pre_reset_valid", bus.rec_valid, 1);
        asyncResetCheck("async_reset");

        // all_finish on the seventh armed cycle; later activity must record nothing
        repeat (3) applyStimulus(0, 4'h0, 0, 4'h0, 0, 0);
        repeat (6) applyStimulus(1, 4'b0100, 0, 4'b0100, 0, 0);
        applyStimulus(1, 4'b0100, 0, 4'b0100, 1, 0);
        repeat (20) applyStimulus(1, 4'b0100, 0, 4'b0100, 0, 0);
        repeat (3) begin
            applyStimulus(0, 4'h0, 0, 4'h0, 0, 0);
            applyStimulus(1, 4'b0001, 0, 4'b0001, 0, 0);
        end
        applyStimulus(0, 4'h0, 0, 4'h0, 0, 0);
        checkOutput("done_valid", bus.rec_valid, 0);
        checkOutput("done_confirmed", bus.dl_confirmed, 0);
        checkOutput("done_drop_cnt", bus.drop_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aesl_deadlock_trace_recorder.md
Name: aesl_deadlock_trace_recorder

Overview:
- Simulation-side consumer of the deadlock report stage's outputs (dl_detect_out, origin, token_clear) plus per-process blocked flags.
- Qualifies transient versus persistent deadlock indications with a stability counter.
- Timestamps each qualified event and buffers trace records in a small show-ahead FIFO, which the testbench drains to print a deadlock history.

Parameters:
- PROC_NUM, 4: number of dataflow processes; width of origin and blocked vectors.
- DEPTH, 8: trace FIFO entries (power of 2, >=2).
- TS_W, 32: timestamp width.
- STABLE_CYC, 16: consecutive cycles dl_detect_in must stay high to be CONFIRMED (>=2).

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous active-low reset
- dl_detect_in  in  1  deadlock indication from the report stage
- origin  in  PROC_NUM  one-hot origin process from the report stage
- token_clear  in  1  token clear pulse from the report stage
- proc_blk_vec  in  PROC_NUM  per-process OR of its proc_dep_vld_vec bits
- all_finish  in  1  design finished; recording stops
- rd_en  in  1  pop the head record (ignored when empty)
- rec_valid  out  1  FIFO not empty
- rec_kind  out  2  head record kind: 01 TRANSIENT, 10 CONFIRMED, 11 CLEARED
- rec_ts  out  TS_W  head record timestamp
- rec_origin  out  PROC_NUM  head record origin snapshot
- rec_blk  out  PROC_NUM  head record proc_blk_vec snapshot
- dl_confirmed  out  1  level, high while in CONFIRM
- overflow  out  1  sticky; a record was dropped
- drop_cnt  out  8  dropped records, saturating at 255

Behaviour:
- Reset (async, reset=0):
  - All outputs 0.
  - FIFO empty; state IDLE; timestamp 0; stab_cnt 0.
- Timestamp: free-running, increments every cycle after reset, saturates at all-ones.
- All inputs are sampled at posedge. State update and FIFO write occur on the same edge. rec_* reflect the new head immediately after that edge.
- FSM:
  - IDLE:
    - dl_detect_in=1 -> ARM.
    - Latch origin, proc_blk_vec and the current timestamp into a pending record.
    - stab_cnt=1.
  - ARM:
    - dl_detect_in=0 -> IDLE; write the pending record with kind TRANSIENT.
    - dl_detect_in=1 and stab_cnt==STABLE_CYC-1 -> CONFIRM; write the pending record with kind CONFIRMED. The timestamp is the original rise time.
    - Otherwise stab_cnt++.
    - token_clear alone has no effect in ARM.
  - CONFIRM:
    - dl_confirmed=1.
    - dl_detect_in=0 or token_clear=1 -> IDLE; write kind CLEARED with the current timestamp and current origin/proc_blk_vec.
  - DONE:
    - Entered from any state on all_finish=1. all_finish has priority over every other transition, and no record is written on that edge.
    - Any pending ARM record is discarded. dl_confirmed=0.
    - DONE is left only by reset. The FIFO remains readable.
- FIFO:
  - Show-ahead: rec_* always show the head entry. rec_valid = !empty.
  - rd_en with rec_valid pops the head.
  - Write when full:
    - With a simultaneous pop, the write is accepted and the count is unchanged.
    - Without a pop, the record is dropped, overflow<=1 and drop_cnt saturates at 255.
  - Simultaneous write and pop when empty: the write is accepted and the pop is ignored (rec_valid was 0).
  - Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Origin is recorded raw. A non-one-hot origin is not checked here.
- Reset mid-operation discards the pending record and all FIFO contents.

Decomposition:
- Shared package aesl_deadlock_pkg holds:
  - kind constants KIND_TRANSIENT=2'b01, KIND_CONFIRMED=2'b10, KIND_CLEARED=2'b11;
  - FSM state enum {IDLE, ARM, CONFIRM, DONE};
  - trace record packed struct {kind, ts, origin, blk}.
- One natural sub-module: aesl_trace_fifo, a parameterized show-ahead sync FIFO with full/empty and a simultaneous rd/wr-when-full rule. The FSM, stability counter, timestamp and drop accounting stay in the top.

Test Plan:
- Glitch: after reset, dl_detect_in=1 for 5 cycles starting at ts=100, origin=4'b0010, blk=4'b0110 -> one record {01, 100, 0010, 0110}; dl_confirmed never high.
- Confirm then clear:
  - dl_detect_in=1 from ts=200, held 30 cycles, origin=4'b1000.
  - Expected: dl_confirmed rises after the edge at ts=215 and falls after the edge at ts=230.
  - Expected records: {10, 200, 1000, …} then {11, 230, …}.
- token_clear in CONFIRM at ts=300 with dl_detect_in still 1 -> CLEARED record ts=300; a new rise is seen next cycle and ARM restarts at ts=301.
- Overflow:
  - 10 transient events, no reads -> 8 records kept (oldest first); overflow=1; drop_cnt=2.
  - Write with rd_en on a full FIFO -> count stays 8 and drop_cnt does not change.
- all_finish during ARM (cycle 7 of 16) -> no record written; state DONE; later dl_detect_in pulses produce nothing.
- Async reset asserted mid-CONFIRM with 3 records queued -> all outputs 0 immediately (without a clock edge); rec_valid=0; overflow=0.
